// File: rtl/load_store_sequencer_if.sv
// Request/response and byte-RAM bus bundle for the load/store sequencer.
// slave is the sequencer's view; master is the requester/RAM side.
`timescale 1ns/1ps
interface load_store_sequencer_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [2:0]            req_mode;
    logic                  req_unsigned;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_re;
    logic                  mem_we;
    logic [7:0]            mem_wdata;
    logic [7:0]            mem_rdata;

    modport master (
        output req_valid, req_write, req_mode, req_unsigned,
        output req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata,
        input  mem_addr, mem_re, mem_we, mem_wdata
    );

    modport slave (
        input  req_valid, req_write, req_mode, req_unsigned,
        input  req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata,
        output mem_addr, mem_re, mem_we, mem_wdata
    );
endinterface

// File: rtl/load_store_sequencer.sv
// Splits one load/store into pipelined single-byte RAM accesses.
// Handles byte/half/word and unaligned word-left/word-right modes.
`timescale 1ns/1ps
module load_store_sequencer #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    load_store_sequencer_if.slave bus
);
    localparam logic [2:0] M_BYTE  = 3'd1;
    localparam logic [2:0] M_HALF  = 3'd2;
    localparam logic [2:0] M_WORD  = 3'd3;
    localparam logic [2:0] M_LEFT  = 3'd4;
    localparam logic [2:0] M_RIGHT = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DRAIN,
        RESP
    } state_t;

    state_t                state;
    logic                  wr_q;
    logic                  uns_q;
    logic [2:0]            mode_q;
    logic [31:0]           wdata_q;
    logic [2:0]            cnt_q;
    logic [1:0]            lane_q;
    logic [31:0]           buf_q;
    logic                  cap_v;
    logic [1:0]            cap_lane;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            wbyte_q;
    logic [31:0]           rdata_q;

    logic [1:0]            a_lo;
    logic [2:0]            n_cnt;
    logic [ADDR_WIDTH-1:0] s_addr;
    logic [1:0]            l0;
    logic                  mem_mode;
    logic [31:0]           merged;
    logic [31:0]           ext;
    logic                  unused_hi;

    function automatic logic [7:0] lane_of(
        input logic [31:0] w,
        input logic [1:0]  l
    );
        return w[{l, 3'b000} +: 8];
    endfunction

    assign a_lo      = bus.req_addr[1:0];
    assign unused_hi = ^bus.req_addr[31:ADDR_WIDTH];

    // Byte count, start address and first lane of the accepted request
    always_comb begin
        n_cnt    = 3'd0;
        s_addr   = bus.req_addr[ADDR_WIDTH-1:0];
        l0       = 2'd0;
        mem_mode = 1'b1;
        case (bus.req_mode)
            M_BYTE:  n_cnt = 3'd1;
            M_HALF:  n_cnt = 3'd2;
            M_WORD:  n_cnt = 3'd4;
            M_LEFT: begin
                n_cnt  = {1'b0, a_lo} + 3'd1;
                s_addr = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
                l0     = 2'd3 - a_lo;
            end
            M_RIGHT: n_cnt = 3'd4 - {1'b0, a_lo};
            default: mem_mode = 1'b0;
        endcase
    end

    // Load buffer with the byte arriving this cycle merged into its lane
    always_comb begin
        merged = buf_q;
        if (cap_v) begin
            merged[{cap_lane, 3'b000} +: 8] = bus.mem_rdata;
        end
    end

    // Sign extension applies only to signed byte and halfword loads
    always_comb begin
        ext = merged;
        case (mode_q)
            M_BYTE: begin
                if (!uns_q) ext = {{24{merged[7]}}, merged[7:0]};
            end
            M_HALF: begin
                if (!uns_q) ext = {{16{merged[15]}}, merged[15:0]};
            end
            default: ext = merged;
        endcase
    end

    // Sequencer FSM with address/lane walk and load data capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wr_q     <= 1'b0;
            uns_q    <= 1'b0;
            mode_q   <= 3'd0;
            wdata_q  <= 32'd0;
            cnt_q    <= 3'd0;
            lane_q   <= 2'd0;
            buf_q    <= 32'd0;
            cap_v    <= 1'b0;
            cap_lane <= 2'd0;
            addr_q   <= '0;
            wbyte_q  <= 8'd0;
            rdata_q  <= 32'd0;
        end else begin
            cap_v    <= (state == ACCESS) && !wr_q;
            cap_lane <= lane_q;
            if (cap_v) begin
                buf_q <= merged;
            end
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        wr_q    <= bus.req_write;
                        uns_q   <= bus.req_unsigned;
                        mode_q  <= bus.req_mode;
                        wdata_q <= bus.req_wdata;
                        cnt_q   <= n_cnt;
                        lane_q  <= l0;
                        addr_q  <= s_addr;
                        wbyte_q <= lane_of(bus.req_wdata, l0);
                        buf_q   <= 32'd0;
                        if (mem_mode) begin
                            state <= ACCESS;
                        end else begin
                            state <= RESP;
                            if (!bus.req_write) rdata_q <= 32'd0;
                        end
                    end
                end
                ACCESS: begin
                    addr_q  <= addr_q + ADDR_WIDTH'(1);
                    lane_q  <= lane_q + 2'd1;
                    wbyte_q <= lane_of(wdata_q, lane_q + 2'd1);
                    cnt_q   <= cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state <= wr_q ? RESP : DRAIN;
                    end
                end
                DRAIN: begin
                    rdata_q <= ext;
                    state   <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.mem_re     = (state == ACCESS) && !wr_q;
    assign bus.mem_we     = (state == ACCESS) && wr_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wbyte_q;
endmodule

// File: tb/tb_load_store_sequencer.sv
// Directed bench for load_store_sequencer against a byte RAM model.
// Each task drives one scenario and checks against hand-computed values.
`timescale 1ns/1ps
module tb_load_store_sequencer;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [7:0] mem [0:65535];

    int          resp_off;
    logic [31:0] got_rdata;
    int          busy_ok;
    logic [15:0] re_addr[$];
    int          re_off[$];
    logic [15:0] we_addr[$];
    logic [7:0]  we_data[$];
    int          we_off[$];

    load_store_sequencer_if #(.ADDR_WIDTH(16)) bus ();

    load_store_sequencer #(.ADDR_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte RAM: one-cycle read latency, write on strobe
    always @(posedge clk) begin
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    task automatic run_req(
        input logic        w,
        input logic [2:0]  m,
        input logic        u,
        input logic [31:0] a,
        input logic [31:0] d
    );
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_write    = w;
        bus.req_mode     = m;
        bus.req_unsigned = u;
        bus.req_addr     = a;
        bus.req_wdata    = d;
        @(posedge clk);
        #1;
        bus.req_valid    = 1'b0;
        bus.req_write    = ~w;
        bus.req_mode     = 3'd3;
        bus.req_unsigned = ~u;
        bus.req_addr     = 32'hDEAD_BEEF;
        bus.req_wdata    = 32'h5A5A_5A5A;
        resp_off  = -1;
        got_rdata = 32'hx;
        busy_ok   = 1;
        re_addr.delete();
        re_off.delete();
        we_addr.delete();
        we_data.delete();
        we_off.delete();
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.req_ready !== 1'b0) busy_ok = 0;
            if (bus.mem_re === 1'b1) begin
                re_addr.push_back(bus.mem_addr);
                re_off.push_back(k);
            end
            if (bus.mem_we === 1'b1) begin
                we_addr.push_back(bus.mem_addr);
                we_data.push_back(bus.mem_wdata);
                we_off.push_back(k);
            end
            if (bus.resp_valid === 1'b1) begin
                resp_off  = k;
                got_rdata = bus.resp_rdata;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_mode = 3'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr = 32'd0;
        bus.req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: ready=%b valid=%b, required 1 0",
                     bus.req_ready, bus.resp_valid);
        end
        checks++;
        if (bus.resp_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_rdata: got %h, required 0", bus.resp_rdata);
        end
        checks++;
        if (bus.mem_re !== 1'b0 || bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: re=%b we=%b, required 0 0",
                     bus.mem_re, bus.mem_we);
        end
        checks++;
        if (bus.mem_addr !== 16'd0 || bus.mem_wdata !== 8'd0) begin
            errors++;
            $display("FAIL reset_mem: addr=%h wdata=%h, required 0 0",
                     bus.mem_addr, bus.mem_wdata);
        end
        rst = 1'b1;
    endtask

    task automatic test_word_load();
        @(negedge clk);
        mem[16'h0100] <= 8'h78;
        mem[16'h0101] <= 8'h56;
        mem[16'h0102] <= 8'h34;
        mem[16'h0103] <= 8'h12;
        run_req(1'b0, 3'd3, 1'b0, 32'h0000_0100, 32'd0);
        checks++;
        if (resp_off !== 6) begin
            errors++;
            $display("FAIL word_resp_cycle: got T+%0d, required T+6", resp_off);
        end
        checks++;
        if (got_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL word_rdata: got %h, required 12345678", got_rdata);
        end
        checks++;
        if (busy_ok !== 1) begin
            errors++;
            $display("FAIL word_ready: got busy_ok=%0d, required 1", busy_ok);
        end
        checks++;
        if (re_addr.size() !== 4 || we_addr.size() !== 0) begin
            errors++;
            $display("FAIL word_count: re=%0d we=%0d, required 4 0",
                     re_addr.size(), we_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (re_addr[i] !== 16'h0100 + 16'(i) || re_off[i] !== i + 1) begin
                    errors++;
                    $display("FAIL word_issue%0d: got %h at T+%0d, required %h at T+%0d",
                             i, re_addr[i], re_off[i], 16'h0100 + 16'(i), i + 1);
                end
            end
        end
    endtask

    task automatic test_left_right_load();
        run_req(1'b0, 3'd4, 1'b0, 32'h0000_0102, 32'd0);
        checks++;
        if (got_rdata !== 32'h3456_7800 || resp_off !== 5) begin
            errors++;
            $display("FAIL lwl: got %h at T+%0d, required 34567800 at T+5",
                     got_rdata, resp_off);
        end
        checks++;
        if (re_addr.size() !== 3) begin
            errors++;
            $display("FAIL lwl_count: got %0d, required 3", re_addr.size());
        end else if (re_addr[0] !== 16'h0100 || re_addr[2] !== 16'h0102) begin
            errors++;
            $display("FAIL lwl_addr: got %h..%h, required 0100..0102",
                     re_addr[0], re_addr[2]);
        end
        run_req(1'b0, 3'd5, 1'b0, 32'h0000_0102, 32'd0);
        checks++;
        if (got_rdata !== 32'h0000_1234 || resp_off !== 4) begin
            errors++;
            $display("FAIL lwr: got %h at T+%0d, required 00001234 at T+4",
                     got_rdata, resp_off);
        end
        checks++;
        if (re_addr.size() !== 2) begin
            errors++;
            $display("FAIL lwr_count: got %0d, required 2", re_addr.size());
        end else if (re_addr[0] !== 16'h0102 || re_addr[1] !== 16'h0103) begin
            errors++;
            $display("FAIL lwr_addr: got %h %h, required 0102 0103",
                     re_addr[0], re_addr[1]);
        end
    endtask

    task automatic test_byte_load();
        @(negedge clk);
        mem[16'h0103] <= 8'h84;
        run_req(1'b0, 3'd1, 1'b0, 32'h0000_0103, 32'd0);
        checks++;
        if (got_rdata !== 32'hFFFF_FF84 || resp_off !== 3) begin
            errors++;
            $display("FAIL lb: got %h at T+%0d, required ffffff84 at T+3",
                     got_rdata, resp_off);
        end
        run_req(1'b0, 3'd1, 1'b1, 32'h0000_0103, 32'd0);
        checks++;
        if (got_rdata !== 32'h0000_0084) begin
            errors++;
            $display("FAIL lbu: got %h, required 00000084", got_rdata);
        end
    endtask

    task automatic test_half_wrap();
        @(negedge clk);
        mem[16'hFFFF] <= 8'h00;
        mem[16'h0000] <= 8'h80;
        run_req(1'b0, 3'd2, 1'b0, 32'h0000_FFFF, 32'd0);
        checks++;
        if (got_rdata !== 32'hFFFF_8000 || resp_off !== 4) begin
            errors++;
            $display("FAIL lh_wrap: got %h at T+%0d, required ffff8000 at T+4",
                     got_rdata, resp_off);
        end
        checks++;
        if (re_addr.size() !== 2) begin
            errors++;
            $display("FAIL lh_wrap_count: got %0d, required 2", re_addr.size());
        end else if (re_addr[0] !== 16'hFFFF || re_addr[1] !== 16'h0000) begin
            errors++;
            $display("FAIL lh_wrap_addr: got %h %h, required ffff 0000",
                     re_addr[0], re_addr[1]);
        end
    endtask

    task automatic test_stores();
        @(negedge clk);
        mem[16'h0200] <= 8'h11;
        mem[16'h0201] <= 8'h22;
        mem[16'h0202] <= 8'h33;
        mem[16'h0203] <= 8'h44;
        run_req(1'b1, 3'd5, 1'b0, 32'h0000_0201, 32'hAABB_CCDD);
        checks++;
        if (resp_off !== 4 || re_addr.size() !== 0) begin
            errors++;
            $display("FAIL swr_resp: got T+%0d re=%0d, required T+4 re=0",
                     resp_off, re_addr.size());
        end
        checks++;
        if (we_addr.size() !== 3) begin
            errors++;
            $display("FAIL swr_count: got %0d, required 3", we_addr.size());
        end else if (we_addr[0] !== 16'h0201 || we_data[0] !== 8'hDD ||
                     we_addr[2] !== 16'h0203 || we_data[2] !== 8'hBB ||
                     we_off[0] !== 1) begin
            errors++;
            $display("FAIL swr_issue: got %h=%h .. %h=%h, required 0201=dd .. 0203=bb",
                     we_addr[0], we_data[0], we_addr[2], we_data[2]);
        end
        checks++;
        if ({mem[16'h0200], mem[16'h0201], mem[16'h0202], mem[16'h0203]}
            !== 32'h11DD_CCBB) begin
            errors++;
            $display("FAIL swr_mem: got %h%h%h%h, required 11ddccbb",
                     mem[16'h0200], mem[16'h0201], mem[16'h0202], mem[16'h0203]);
        end
        run_req(1'b1, 3'd4, 1'b0, 32'h0000_0201, 32'hAABB_CCDD);
        checks++;
        if (resp_off !== 3 || we_addr.size() !== 2) begin
            errors++;
            $display("FAIL swl_resp: got T+%0d we=%0d, required T+3 we=2",
                     resp_off, we_addr.size());
        end
        checks++;
        if ({mem[16'h0200], mem[16'h0201], mem[16'h0202], mem[16'h0203]}
            !== 32'hBBAA_CCBB) begin
            errors++;
            $display("FAIL swl_mem: got %h%h%h%h, required bbaaccbb",
                     mem[16'h0200], mem[16'h0201], mem[16'h0202], mem[16'h0203]);
        end
    endtask

    task automatic test_reset_abort();
        int seen;
        int not_ready;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_mode  = 3'd3;
        bus.req_addr  = 32'h0000_0100;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mem_re !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: mem_re=%b, required 1", bus.mem_re);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.mem_re !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_now: re=%b ready=%b, required 0 1",
                     bus.mem_re, bus.req_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        not_ready = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) seen++;
            if (bus.req_ready !== 1'b1) not_ready++;
        end
        checks++;
        if (seen !== 0 || not_ready !== 0) begin
            errors++;
            $display("FAIL abort_after: resp=%0d busy=%0d, required 0 0",
                     seen, not_ready);
        end
    endtask

    task automatic test_none_mode();
        run_req(1'b0, 3'd1, 1'b1, 32'h0000_0100, 32'd0);
        checks++;
        if (got_rdata !== 32'h0000_0078) begin
            errors++;
            $display("FAIL pre_none_lbu: got %h, required 00000078", got_rdata);
        end
        run_req(1'b0, 3'd6, 1'b0, 32'h0000_0100, 32'd0);
        checks++;
        if (resp_off !== 1 || got_rdata !== 32'd0) begin
            errors++;
            $display("FAIL none_load: got %h at T+%0d, required 0 at T+1",
                     got_rdata, resp_off);
        end
        checks++;
        if (re_addr.size() !== 0 || we_addr.size() !== 0) begin
            errors++;
            $display("FAIL none_load_mem: re=%0d we=%0d, required 0 0",
                     re_addr.size(), we_addr.size());
        end
        run_req(1'b1, 3'd0, 1'b0, 32'h0000_0200, 32'h1234_5678);
        checks++;
        if (resp_off !== 1 || we_addr.size() !== 0 || mem[16'h0200] !== 8'hBB) begin
            errors++;
            $display("FAIL none_store: T+%0d we=%0d mem=%h, required T+1 0 bb",
                     resp_off, we_addr.size(), mem[16'h0200]);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_word_load();
        test_left_right_load();
        test_byte_load();
        test_half_wrap();
        test_stores();
        test_reset_abort();
        test_none_mode();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/load_store_sequencer.md
Name: load_store_sequencer

Overview:
CPU-side initiator that turns one load/store request into a sequence of single-byte accesses on a byte-wide synchronous RAM port. Supports the BYTE / HALFWORD / WORD / WORDLEFT / WORDRIGHT access modes (lb/lh/lw/lwl/lwr/sb/sh/sw/swl/swr) with unsigned and sign-extended loads. Sits between the execute stage and a single-port byte RAM, and stalls the pipeline through req_ready.

Parameters:
ADDR_WIDTH, 16, byte-address width driven onto mem_addr; req_addr bits above ADDR_WIDTH-1 are ignored.

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  unit idle; request accepted when req_valid && req_ready
req_write  input  1  1 = store, 0 = load
req_mode  input  3  0 NONE, 1 BYTE, 2 HALFWORD, 3 WORD, 4 WORDLEFT, 5 WORDRIGHT; 6 and 7 act as NONE
req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend (BYTE/HALFWORD only)
req_addr  input  32  byte address
req_wdata  input  32  store data
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  load result; holds until the next load completes
mem_addr  output  ADDR_WIDTH  byte address to RAM
mem_re  output  1  RAM read strobe
mem_we  output  1  RAM write strobe
mem_wdata  output  8  RAM write byte
mem_rdata  input  8  RAM read byte, valid the cycle after mem_re

Behaviour:
- Reset (async, rst=0): state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; mem_re=0; mem_we=0; mem_addr=0; mem_wdata=0. mem_re and mem_we are decoded from state, so they drop immediately on reset assertion.
- States: IDLE, ACCESS, DRAIN (loads only), RESP. req_ready=1 only in IDLE.
- Accept in cycle T: register mode, write, unsigned, data, a=addr[1:0], count N, start address S and first lane L0.
- N: BYTE 1, HALFWORD 2, WORD 4, WORDLEFT a+1, WORDRIGHT 4-a.
- S: WORDLEFT uses {addr[15:2],2'b00}; all other modes use addr[15:0].
- L0: WORDLEFT uses 3-a; all other modes use 0.
- Byte i (i=0..N-1) is at S+i, modulo 2^ADDR_WIDTH (0xFFFF+1 wraps to 0x0000), and maps to data lane L0+i. Lane k is bits [8k+7:8k].
- ACCESS runs cycles T+1..T+N; byte i is issued in cycle T+1+i.
  - Store: mem_we=1, mem_wdata = req_wdata lane (L0+i).
  - Load: mem_re=1. mem_rdata captured at the end of cycle T+2+i into lane L0+i.
  - Issues are pipelined; there are no gaps between bytes.
- Store completion: RESP in cycle T+N+1 (resp_valid=1); IDLE at T+N+2.
- Load completion: DRAIN in cycle T+N+1 captures the last byte; RESP in cycle T+N+2 drives resp_valid=1 and updates resp_rdata.
- Load result assembly:
  - Lanes not written are 0.
  - BYTE signed: bits [31:8] = bit 7. HALFWORD signed: bits [31:16] = bit 15.
  - WORD, WORDLEFT and WORDRIGHT are never extended.
  - req_unsigned is ignored for stores.
- NONE/6/7: accepted, no memory access, RESP in cycle T+1. A load in these modes sets resp_rdata=0.
- req_valid while busy: ignored (not queued). The requester must hold req_valid until it is accepted.
- Inputs are sampled only in the accept cycle; later changes to req_* have no effect on an in-flight access.
- Reset mid-operation: the access is aborted, no resp_valid is produced, and stores already issued are not undone.

Test Plan:
- Preload 0x0100..0x0103 = 78,56,34,12; load WORD at 0x0100, accept at T -> mem_re in T+1..T+4 with mem_addr 0x0100..0x0103 -> resp_valid at T+6, resp_rdata=0x12345678, req_ready=0 from T+1 to T+6.
- [0x0103]=0x84; load BYTE signed at 0x0103 -> 0xFFFFFF84; same load with req_unsigned=1 -> 0x00000084.
- [0xFFFF]=0x00, [0x0000]=0x80; load HALFWORD signed at 0x0000FFFF -> mem_addr sequence 0xFFFF, 0x0000 -> 0xFFFF8000.
- Same preload as the WORD test; load WORDLEFT at 0x0102 -> reads 0x0100, 0x0101, 0x0102 -> 0x34567800. Load WORDRIGHT at 0x0102 -> reads 0x0102, 0x0103 -> 0x00001234.
- Store WORDRIGHT 0xAABBCCDD at 0x0201 -> writes 0x0201=DD, 0x0202=CC, 0x0203=BB; 0x0200 untouched; resp_valid at T+4. Store WORDLEFT same data at 0x0201 -> writes 0x0200=BB, 0x0201=AA; resp_valid at T+3.
- Assert rst=0 during cycle T+2 of a WORD load -> mem_re=0 immediately, no resp_valid, req_ready=1 after release. Then mode 6 load -> resp_valid at T+1, resp_rdata=0, no mem_re or mem_we.
